spatial_encoder_folded: RTL and testbench
=========================================

Name: spatial_encoder_folded

Overview:
- Consumes the serial per-channel item-memory / projection fold stream from the HV generator stage.
- Per fold: binds each beat (im XOR projm), bundles the bound vectors per modality (GSR, ECG, EEG) by bitwise majority, then fuses the three modality vectors by 3-input bitwise majority.
- Emits one FOLD_WIDTH-bit fused fold per fold to the downstream temporal encoder / associative memory.

Parameters:
- FOLD_WIDTH, 2000, bits per fold; a factor of HV dimension 2000.
- NUM_FOLDS, 1, folds per hypervector; 1 means no folding.
- NUM_FOLDS_WIDTH, 1, width of fold index; at least ceillog2(NUM_FOLDS), minimum 1.
- GSR_CH, 32, GSR beats per fold; must be at least 1.
- ECG_CH, 77, ECG beats per fold; must be at least 1.
- EEG_CH, 105, EEG beats per fold; must be at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- hv_valid  in  1  input beat valid.
- hv_ready  out  1  input beat ready.
- im_in  in  FOLD_WIDTH  item-memory fold for the current channel.
- projm_in  in  FOLD_WIDTH  projection fold for the current channel.
- dout_valid  out  1  fused fold valid.
- dout_ready  in  1  downstream ready.
- dout  out  FOLD_WIDTH  fused fold.
- dout_fold  out  NUM_FOLDS_WIDTH  index of the fold on dout.
- dout_last  out  1  high with the last fold of a hypervector (dout_fold == NUM_FOLDS-1).

Behaviour:
- Beat accepted on hv_valid && hv_ready. bound = im_in ^ projm_in.
- States: S_GSR → S_ECG → S_EEG → S_GSR. State advances on acceptance of the last beat of a modality (channel count == CH-1). The channel counter clears on each advance.
- One shared accumulator array: FOLD_WIDTH counters, each $clog2(max(GSR_CH, ECG_CH, EEG_CH)+1) bits wide.
- Each accepted non-final beat: counter[b] += bound[b].
- Final beat of a modality:
  - Modality bit b = 1 iff 2*(counter[b] + bound[b]) > CH, evaluated on the count including that beat.
  - Ties (even CH) resolve to 0.
  - All counters clear in the same cycle.
- GSR result is stored in gsr_hv; ECG result is stored in ecg_hv.
- On the final EEG beat, the EEG result is computed combinationally. dout register <= maj(gsr_hv, ecg_hv, eeg). dout_valid is set the next cycle: latency 1 cycle after the last beat.
- dout_fold:
  - Holds the fold counter value for the fold in dout.
  - The fold counter increments when each fused fold is loaded; it wraps NUM_FOLDS-1 → 0.
  - dout_last = (dout_fold == NUM_FOLDS-1).
- Output handshake:
  - dout, dout_fold and dout_valid are held stable until dout_valid && dout_ready.
  - dout_valid clears on fire unless a new fold loads in the same cycle. A simultaneous fire and load keeps dout_valid high with the new data.
- Backpressure: hv_ready = !dout_valid || dout_ready. A pending unconsumed output stalls input at any point in the fold; no beat is lost or duplicated.
- Reset, including mid-fold:
  - State S_GSR; channel counter, fold counter and accumulators 0; gsr_hv and ecg_hv 0.
  - dout_valid 0, dout 0, dout_fold 0, dout_last 0 when NUM_FOLDS > 1.
  - A partial fold is discarded.
- hv_ready resets to 1.

Optional Feature:
- Macro: SPATIAL_MODALITY_OUT_EN.
- Defined:
  - Adds outputs gsr_out, ecg_out, eeg_out, each FOLD_WIDTH bits.
  - They are registered alongside dout with the per-modality majority vectors of the same fold and obey the same valid/ready and hold rules.
  - Each resets to 0.
- Undefined: the ports are absent, and gsr_hv/ecg_hv are the only modality storage.

Test Plan:
All scenarios use FOLD_WIDTH=8, GSR_CH=2, ECG_CH=3, EEG_CH=3, NUM_FOLDS=2 and dout_ready=1 unless noted.
- All 8 beats im=8'hFF, projm=8'h00 → one cycle after beat 8, dout_valid=1, dout=8'hFF, dout_fold=0, dout_last=0.
- Bound sequence:
  - Stimulus: GSR 8'hF0, 8'h0F; ECG 8'hFF, 8'hFF, 8'h00; EEG 8'hAA ×3.
  - Response: GSR ties give 8'h00, ECG 8'hFF, EEG 8'hAA → dout=8'hAA.
- Two consecutive folds → dout_fold 0 then 1 with dout_last=1 on the second; third fold shows dout_fold=0.
- dout_ready=0 after the first fold completes:
  - hv_ready goes low and dout is held stable for 5 cycles.
  - Raising dout_ready: fire, and input resumes the same cycle.
  - Second fold result is correct.
- rst asserted after 4 beats, then a full fold of im=8'h0F, projm=8'h00 → dout=8'h0F, dout_fold=0; no contamination from the discarded beats.
- SPATIAL_MODALITY_OUT_EN defined, scenario-2 stimulus → gsr_out=8'h00, ecg_out=8'hFF, eeg_out=8'hAA, dout=8'hAA.

Source files
------------

// File: rtl/spatial_encoder_folded.sv
// spatial_encoder_folded: binds item-memory and projection folds, bundles each
// modality (GSR, ECG, EEG) by bitwise majority and fuses the three modality
// vectors with a 3-input majority. One fused fold is produced per input fold.
// Optional build macro SPATIAL_MODALITY_OUT_EN adds gsr_out/ecg_out/eeg_out.
//
// Handshakes: an input beat transfers on a clock edge where hv_valid && hv_ready,
// and an output fold transfers where dout_valid && dout_ready. A producer holds
// its payload stable while valid is high and not yet accepted. Valid never
// depends combinationally on ready.
module spatial_encoder_folded #(
  parameter int FOLD_WIDTH      = 2000,
  parameter int NUM_FOLDS       = 1,
  parameter int NUM_FOLDS_WIDTH = 1,
  parameter int GSR_CH          = 32,
  parameter int ECG_CH          = 77,
  parameter int EEG_CH          = 105
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hv_valid,
  output logic                       hv_ready,
  input  logic [FOLD_WIDTH-1:0]      im_in,
  input  logic [FOLD_WIDTH-1:0]      projm_in,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [FOLD_WIDTH-1:0]      dout,
  output logic [NUM_FOLDS_WIDTH-1:0] dout_fold,
`ifdef SPATIAL_MODALITY_OUT_EN
  output logic [FOLD_WIDTH-1:0]      gsr_out,
  output logic [FOLD_WIDTH-1:0]      ecg_out,
  output logic [FOLD_WIDTH-1:0]      eeg_out,
`endif
  output logic                       dout_last
);

  localparam int MAX_CH = (GSR_CH > ECG_CH) ? ((GSR_CH > EEG_CH) ? GSR_CH : EEG_CH)
                                            : ((ECG_CH > EEG_CH) ? ECG_CH : EEG_CH);
  localparam int CNT_W = $clog2(MAX_CH + 1);
  localparam logic [NUM_FOLDS_WIDTH-1:0] LAST_FOLD = NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);

  typedef enum logic [1:0] {
    S_GSR = 2'd0,
    S_ECG = 2'd1,
    S_EEG = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            ch_cnt_q;
  logic [CNT_W-1:0]            acc_q [FOLD_WIDTH];
  logic [FOLD_WIDTH-1:0]       gsr_hv_q, ecg_hv_q;
  logic [FOLD_WIDTH-1:0]       dout_q;
  logic                        dout_valid_q;
  logic [NUM_FOLDS_WIDTH-1:0]  dout_fold_q, fold_cnt_q;

  logic [FOLD_WIDTH-1:0]       bound;
  logic [FOLD_WIDTH-1:0]       maj_vec;
  logic [FOLD_WIDTH-1:0]       fused;
  logic [CNT_W-1:0]            cur_ch;
  logic                        in_fire, out_fire, last_beat, load;

  assign bound      = im_in ^ projm_in;
  assign hv_ready   = !dout_valid_q || dout_ready;
  assign in_fire    = hv_valid && hv_ready;
  assign out_fire   = dout_valid_q && dout_ready;
  assign last_beat  = (ch_cnt_q == cur_ch - 1'b1);
  assign load       = in_fire && last_beat && (state_q == S_EEG);
  assign fused      = (gsr_hv_q & ecg_hv_q) | (gsr_hv_q & maj_vec) | (ecg_hv_q & maj_vec);

  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign dout_fold  = dout_fold_q;
  assign dout_last  = (dout_fold_q == LAST_FOLD);

  // Channel count of the modality currently being bundled.
  always_comb begin
    cur_ch = CNT_W'(GSR_CH);
    case (state_q)
      S_ECG:   cur_ch = CNT_W'(ECG_CH);
      S_EEG:   cur_ch = CNT_W'(EEG_CH);
      default: cur_ch = CNT_W'(GSR_CH);
    endcase
  end

  // Majority including the current beat: 2*(count+bound) > CH, ties give 0.
  always_comb begin
    maj_vec = '0;
    for (int b = 0; b < FOLD_WIDTH; b++) begin
      maj_vec[b] = ({1'b0, acc_q[b], 1'b0} + {{CNT_W{1'b0}}, bound[b], 1'b0})
                   > {2'b00, cur_ch};
    end
  end

  // Modality sequencing: advance on the last accepted beat of each modality.
  always_comb begin
    state_d = state_q;
    if (in_fire && last_beat) begin
      case (state_q)
        S_GSR:   state_d = S_ECG;
        S_ECG:   state_d = S_EEG;
        default: state_d = S_GSR;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_GSR;
    else     state_q <= state_d;
  end

  // Channel counter within the current modality.
  always_ff @(posedge clk) begin
    if (rst)                       ch_cnt_q <= '0;
    else if (in_fire && last_beat) ch_cnt_q <= '0;
    else if (in_fire)              ch_cnt_q <= ch_cnt_q + 1'b1;
  end

  // Shared per-bit accumulators; cleared when a modality completes.
  always_ff @(posedge clk) begin
    for (int b = 0; b < FOLD_WIDTH; b++) begin
      if (rst)                       acc_q[b] <= '0;
      else if (in_fire && last_beat) acc_q[b] <= '0;
      else if (in_fire)              acc_q[b] <= acc_q[b] + CNT_W'(bound[b]);
    end
  end

  // Stored GSR and ECG modality vectors for the fold in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      gsr_hv_q <= '0;
      ecg_hv_q <= '0;
    end else if (in_fire && last_beat) begin
      if (state_q == S_GSR) gsr_hv_q <= maj_vec;
      if (state_q == S_ECG) ecg_hv_q <= maj_vec;
    end
  end

  // Fold counter advances each time a fused fold is loaded.
  always_ff @(posedge clk) begin
    if (rst)       fold_cnt_q <= '0;
    else if (load) fold_cnt_q <= (fold_cnt_q == LAST_FOLD) ? '0 : fold_cnt_q + 1'b1;
  end

  // Output register: load wins over fire so a simultaneous pair keeps valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_fold_q  <= '0;
    end else if (load) begin
      dout_q       <= fused;
      dout_valid_q <= 1'b1;
      dout_fold_q  <= fold_cnt_q;
    end else if (out_fire) begin
      dout_valid_q <= 1'b0;
    end
  end

`ifdef SPATIAL_MODALITY_OUT_EN
  // Per-modality vectors registered alongside the fused fold.
  always_ff @(posedge clk) begin
    if (rst) begin
      gsr_out <= '0;
      ecg_out <= '0;
      eeg_out <= '0;
    end else if (load) begin
      gsr_out <= gsr_hv_q;
      ecg_out <= ecg_hv_q;
      eeg_out <= maj_vec;
    end
  end
`endif

endmodule

// File: tb/tb_spatial_encoder_folded.sv
// Bench for spatial_encoder_folded with FOLD_WIDTH=8, GSR/ECG/EEG = 2/3/3 beats,
// NUM_FOLDS=2. Build with SPATIAL_MODALITY_OUT_EN to also check modality outputs.
module tb_spatial_encoder_folded;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         hv_valid;
  logic         hv_ready;
  logic [W-1:0] im_in;
  logic [W-1:0] projm_in;
  logic         dout_valid;
  logic         dout_ready;
  logic [W-1:0] dout;
  logic [0:0]   dout_fold;
  logic         dout_last;
`ifdef SPATIAL_MODALITY_OUT_EN
  logic [W-1:0] gsr_out, ecg_out, eeg_out;
  logic [23:0]  exp_mod_q[$];
  logic [23:0]  e_mod;
`endif

  int           n_checks = 0;
  int           n_errors = 0;
  logic [9:0]   exp_q[$];      // {last, fold, dout}
  logic [9:0]   e_out;
  logic         exp_fold;
  logic [7:0]   im_a [8];
  logic [7:0]   pm_a [8];
  logic [7:0]   d_hold;

  spatial_encoder_folded #(
    .FOLD_WIDTH(W), .NUM_FOLDS(2), .NUM_FOLDS_WIDTH(1),
    .GSR_CH(2), .ECG_CH(3), .EEG_CH(3)
  ) dut (
    .clk(clk), .rst(rst),
    .hv_valid(hv_valid), .hv_ready(hv_ready),
    .im_in(im_in), .projm_in(projm_in),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout(dout), .dout_fold(dout_fold),
`ifdef SPATIAL_MODALITY_OUT_EN
    .gsr_out(gsr_out), .ecg_out(ecg_out), .eeg_out(eeg_out),
`endif
    .dout_last(dout_last)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: bit-count majority per modality, then 3-way vote.
  // Returns {gsr, ecg, eeg, fused}.
  function automatic logic [31:0] model(input logic [7:0] b [8]);
    logic [7:0] g, e, x, f;
    int cg, ce, cx;
    for (int k = 0; k < 8; k++) begin
      cg = int'(b[0][k]) + int'(b[1][k]);
      ce = int'(b[2][k]) + int'(b[3][k]) + int'(b[4][k]);
      cx = int'(b[5][k]) + int'(b[6][k]) + int'(b[7][k]);
      g[k] = (2 * cg > 2);
      e[k] = (2 * ce > 3);
      x[k] = (2 * cx > 3);
      f[k] = (int'(g[k]) + int'(e[k]) + int'(x[k])) >= 2;
    end
    return {g, e, x, f};
  endfunction

  task automatic push_exp(input logic [7:0] ims [8], input logic [7:0] pms [8]);
    logic [7:0] b [8];
    logic [31:0] r;
    for (int i = 0; i < 8; i++) b[i] = ims[i] ^ pms[i];
    r = model(b);
    exp_q.push_back({(exp_fold == 1'b1), exp_fold, r[7:0]});
`ifdef SPATIAL_MODALITY_OUT_EN
    exp_mod_q.push_back(r[31:8]);
`endif
    exp_fold = ~exp_fold;
  endtask

  // Drive one beat starting at a negedge; returns at the negedge after acceptance.
  task automatic send_beat(input logic [7:0] im, input logic [7:0] pm);
    logic rdy;
    logic done;
    done = 1'b0;
    hv_valid = 1'b1; im_in = im; projm_in = pm;
    for (int c = 0; c < 50 && !done; c++) begin
      #1 rdy = hv_ready;
      @(posedge clk);
      if (rdy) done = 1'b1;
      @(negedge clk);
    end
    hv_valid = 1'b0;
    if (!done) check("beat_accept", 32'(done), 32'd1);
  endtask

  task automatic send_fold(input logic [7:0] ims [8], input logic [7:0] pms [8]);
    push_exp(ims, pms);
    for (int i = 0; i < 8; i++) send_beat(ims[i], pms[i]);
  endtask

  task automatic load_scenario2();
    im_a = '{8'hF0, 8'h0F, 8'hFF, 8'hFF, 8'h00, 8'hAA, 8'hAA, 8'hAA};
    pm_a = '{default: 8'h00};
  endtask

  task automatic load_random();
    for (int i = 0; i < 8; i++) begin
      im_a[i] = 8'($urandom_range(0, 255));
      pm_a[i] = 8'($urandom_range(0, 255));
    end
  endtask

  // Scoreboard: compare each output transfer against the queue head.
  always @(negedge clk) begin
    if (rst === 1'b0 && dout_valid === 1'b1 && dout_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $error("FAIL unexpected_output observed=%0h expected=none", dout);
      end else begin
        e_out = exp_q.pop_front();
        check("dout_fire", {22'd0, dout_last, dout_fold, dout}, {22'd0, e_out});
`ifdef SPATIAL_MODALITY_OUT_EN
        e_mod = exp_mod_q.pop_front();
        check("modality_fire", {8'd0, gsr_out, ecg_out, eeg_out}, {8'd0, e_mod});
`endif
      end
    end
  end

  initial begin
    rst = 1'b1; hv_valid = 1'b0; im_in = '0; projm_in = '0; dout_ready = 1'b1;
    exp_fold = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_dout",       32'(dout),       32'd0);
    check("rst_dout_fold",  32'(dout_fold),  32'd0);
    check("rst_dout_last",  32'(dout_last),  32'd0);
    check("rst_hv_ready",   32'(hv_ready),   32'd1);

    // All-ones bound, latency of one cycle after the final beat.
    im_a = '{default: 8'hFF};
    pm_a = '{default: 8'h00};
    push_exp(im_a, pm_a);
    for (int i = 0; i < 7; i++) send_beat(im_a[i], pm_a[i]);
    check("pre_last_valid", 32'(dout_valid), 32'd0);
    send_beat(im_a[7], pm_a[7]);
    check("a_valid", 32'(dout_valid), 32'd1);
    check("a_dout",  32'(dout),       32'hFF);
    check("a_fold",  32'(dout_fold),  32'd0);
    check("a_last",  32'(dout_last),  32'd0);
    @(negedge clk);
    check("a_valid_clear", 32'(dout_valid), 32'd0);

    // Ties in GSR, majority in ECG and EEG; second fold of the hypervector.
    load_scenario2();
    send_fold(im_a, pm_a);
    check("b_dout", 32'(dout),      32'hAA);
    check("b_fold", 32'(dout_fold), 32'd1);
    check("b_last", 32'(dout_last), 32'd1);
`ifdef SPATIAL_MODALITY_OUT_EN
    check("b_gsr_out", 32'(gsr_out), 32'h00);
    check("b_ecg_out", 32'(ecg_out), 32'hFF);
    check("b_eeg_out", 32'(eeg_out), 32'hAA);
`endif

    // Third fold wraps the fold index.
    load_random();
    send_fold(im_a, pm_a);
    check("c_fold", 32'(dout_fold), 32'd0);
    check("c_last", 32'(dout_last), 32'd0);

    // Backpressure: hold a completed fold while the next fold's first beat waits.
    @(posedge clk);
    #1 dout_ready = 1'b0;
    @(negedge clk);
    load_random();
    send_fold(im_a, pm_a);
    d_hold = exp_q[0][7:0];
    load_scenario2();
    push_exp(im_a, pm_a);
    hv_valid = 1'b1; im_in = im_a[0]; projm_in = pm_a[0];
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stall_hv_ready", 32'(hv_ready),   32'd0);
      check("stall_valid",    32'(dout_valid), 32'd1);
      check("stall_dout",     32'(dout),       32'(d_hold));
      @(negedge clk);
    end
    @(posedge clk);
    #1 dout_ready = 1'b1;
    @(negedge clk);
    #1 check("resume_hv_ready", 32'(hv_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    hv_valid = 1'b0;
    check("resume_valid_clear", 32'(dout_valid), 32'd0);
    for (int i = 1; i < 8; i++) send_beat(im_a[i], pm_a[i]);
    check("e_dout", 32'(dout),      32'hAA);
    check("e_fold", 32'(dout_fold), 32'd0);

    // Reset in the middle of a fold discards the partial fold.
    for (int i = 0; i < 4; i++) send_beat(8'hAA, 8'h55);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_fold = 1'b0;
    @(negedge clk);
    check("mrst_valid",    32'(dout_valid), 32'd0);
    check("mrst_dout",     32'(dout),       32'd0);
    check("mrst_hv_ready", 32'(hv_ready),   32'd1);
    im_a = '{default: 8'h0F};
    pm_a = '{default: 8'h00};
    send_fold(im_a, pm_a);
    check("f_valid", 32'(dout_valid), 32'd1);
    check("f_dout",  32'(dout),       32'h0F);
    check("f_fold",  32'(dout_fold),  32'd0);

    // Drain the scoreboard with a bounded wait.
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(negedge clk);
    check("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
